// File: rtl/mpx_cfg_sequencer_if.sv
// -----------------------------------------------------------------------------
// mpx_cfg_sequencer_if
// Bundles the firmware-facing control, table-RAM read port and datapath
// config outputs of mpx_cfg_sequencer.
//   slave  : the sequencer side (drives status, mem_addr/mem_rd, cfg words).
//   master : the surrounding system (drives start/abort/params, mem_rdata).
// Optional: MPX_CFG_CHECKSUM_EN adds the 16-bit cksum status output.
// -----------------------------------------------------------------------------
interface mpx_cfg_sequencer_if #(
   parameter int DATA_WIDTH = 25,
   parameter int ADDR_WIDTH = 8
);
   // control / status
   logic                  start;
   logic                  target;
   logic [ADDR_WIDTH-1:0] base_addr;
   logic [ADDR_WIDTH:0]   count;
   logic                  abort;
   logic                  busy;
   logic                  done;
   logic                  err;
   logic                  mute;
   // table RAM read port (one-cycle read latency)
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic                  mem_rd;
   logic [DATA_WIDTH-1:0] mem_rdata;
   // datapath config outputs
   logic [DATA_WIDTH-1:0] filter_cfg_din;
   logic                  filter_cfg_ce;
   logic [7:0]            dds_cfg;
   logic                  dds_cfg_ce;
`ifdef MPX_CFG_CHECKSUM_EN
   logic [15:0]           cksum;
`endif

   modport slave (
      input  start, target, base_addr, count, abort, mem_rdata,
`ifdef MPX_CFG_CHECKSUM_EN
      output cksum,
`endif
      output busy, done, err, mute, mem_addr, mem_rd,
      output filter_cfg_din, filter_cfg_ce, dds_cfg, dds_cfg_ce
   );

   modport master (
      output start, target, base_addr, count, abort, mem_rdata,
`ifdef MPX_CFG_CHECKSUM_EN
      input  cksum,
`endif
      input  busy, done, err, mute, mem_addr, mem_rd,
      input  filter_cfg_din, filter_cfg_ce, dds_cfg, dds_cfg_ce
   );
endinterface

// File: rtl/mpx_cfg_sequencer.sv
// -----------------------------------------------------------------------------
// mpx_cfg_sequencer
// Streams a contiguous word table from the local coefficient RAM into either
// the L/R pre-emphasis FIR coefficient chain (target 0) or the pilot DDS
// waveform ROM (target 1), one config strobe per word with GAP idle cycles
// between strobes. Holds mute while the FIR taps are being rewritten.
//
// Ports:
//   clk      register/config clock
//   reset_n  asynchronous active-low reset
//   bus      mpx_cfg_sequencer_if.slave:
//              start/target/base_addr/count/abort  -> load request / cancel
//              busy/done/err/mute                  <- status (registered)
//              mem_addr/mem_rd/mem_rdata           <-> table RAM read port
//              filter_cfg_din/_ce, dds_cfg/_ce     <- config words + strobes
//
// Optional macro MPX_CFG_CHECKSUM_EN: adds bus.cksum, the wrapping 16-bit
// sum of mem_rdata[15:0] over the words strobed by the last load.
// -----------------------------------------------------------------------------
module mpx_cfg_sequencer #(
   parameter int DATA_WIDTH = 25,
   parameter int ADDR_WIDTH = 8,
   parameter int GAP        = 2
) (
   input  logic                clk,
   input  logic                reset_n,
   mpx_cfg_sequencer_if.slave  bus
);

   // PACE counter only ever holds GAP-1 down to 0
   localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

   typedef enum logic [2:0] {
      S_IDLE, S_READ, S_LATCH, S_STROBE, S_PACE, S_DONE
   } state_t;

   state_t                state_q;
   logic                  tgt_q;
   logic [ADDR_WIDTH-1:0] base_q;
   logic [ADDR_WIDTH:0]   words_q;
   logic [ADDR_WIDTH:0]   idx_q;
   logic [GW-1:0]         pace_q;
   logic                  busy_q, done_q, err_q, mute_q;
   logic                  rd_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] fdin_q;
   logic                  fce_q;
   logic [7:0]            dds_q;
   logic                  dce_q;
`ifdef MPX_CFG_CHECKSUM_EN
   logic [15:0]           cksum_q;
`endif

   logic [ADDR_WIDTH:0]   idx_d;
   logic                  last_d;
   logic [ADDR_WIDTH-1:0] addr_next_d;   // address of word idx+1 (GAP = 0 path)
   logic [ADDR_WIDTH-1:0] addr_cur_d;    // address of word idx (after PACE)

   always_comb begin
      idx_d       = idx_q + 1'b1;
      last_d      = (idx_d == words_q);
      addr_next_d = base_q + idx_d[ADDR_WIDTH-1:0];
      addr_cur_d  = base_q + idx_q[ADDR_WIDTH-1:0];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         tgt_q   <= 1'b0;
         base_q  <= '0;
         words_q <= '0;
         idx_q   <= '0;
         pace_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         mute_q  <= 1'b0;
         rd_q    <= 1'b0;
         addr_q  <= '0;
         fdin_q  <= '0;
         fce_q   <= 1'b0;
         dds_q   <= '0;
         dce_q   <= 1'b0;
`ifdef MPX_CFG_CHECKSUM_EN
         cksum_q <= '0;
`endif
      end else begin
         // single-cycle pulses default low
         done_q <= 1'b0;
         err_q  <= 1'b0;
         rd_q   <= 1'b0;
         fce_q  <= 1'b0;
         dce_q  <= 1'b0;
         case (state_q)
            S_IDLE, S_DONE: begin
               state_q <= S_IDLE;
               // abort is irrelevant here; only start is looked at
               if (bus.start) begin
                  if (bus.count != '0) begin
                     tgt_q   <= bus.target;
                     base_q  <= bus.base_addr;
                     words_q <= bus.count;
                     idx_q   <= '0;
                     busy_q  <= 1'b1;
                     mute_q  <= ~bus.target;
                     rd_q    <= 1'b1;
                     addr_q  <= bus.base_addr;
                     state_q <= S_READ;
`ifdef MPX_CFG_CHECKSUM_EN
                     cksum_q <= '0;
`endif
                  end else begin
                     err_q <= 1'b1;
                  end
               end
            end
            default: begin
               if (bus.abort) begin
                  // abort beats every transition, including the final STROBE
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
                  mute_q  <= 1'b0;
                  err_q   <= 1'b1;
               end else begin
                  if (bus.start) err_q <= 1'b1;   // start while busy is refused
                  case (state_q)
                     S_READ: state_q <= S_LATCH;
                     S_LATCH: begin
                        if (tgt_q) begin
                           dds_q <= bus.mem_rdata[7:0];
                           dce_q <= 1'b1;
                        end else begin
                           fdin_q <= bus.mem_rdata;
                           fce_q  <= 1'b1;
                        end
`ifdef MPX_CFG_CHECKSUM_EN
                        cksum_q <= cksum_q + bus.mem_rdata[15:0];
`endif
                        state_q <= S_STROBE;
                     end
                     S_STROBE: begin
                        idx_q <= idx_d;
                        if (last_d) begin
                           done_q  <= 1'b1;
                           busy_q  <= 1'b0;
                           mute_q  <= 1'b0;
                           state_q <= S_DONE;
                        end else if (GAP > 0) begin
                           pace_q  <= GW'(GAP - 1);
                           state_q <= S_PACE;
                        end else begin
                           rd_q    <= 1'b1;
                           addr_q  <= addr_next_d;
                           state_q <= S_READ;
                        end
                     end
                     S_PACE: begin
                        if (pace_q == '0) begin
                           rd_q    <= 1'b1;
                           addr_q  <= addr_cur_d;
                           state_q <= S_READ;
                        end else begin
                           pace_q <= pace_q - GW'(1);
                        end
                     end
                     default: state_q <= S_IDLE;
                  endcase
               end
            end
         endcase
      end
   end

   assign bus.busy           = busy_q;
   assign bus.done           = done_q;
   assign bus.err            = err_q;
   assign bus.mute           = mute_q;
   assign bus.mem_rd         = rd_q;
   assign bus.mem_addr       = addr_q;
   assign bus.filter_cfg_din = fdin_q;
   assign bus.filter_cfg_ce  = fce_q;
   assign bus.dds_cfg        = dds_q;
   assign bus.dds_cfg_ce     = dce_q;
`ifdef MPX_CFG_CHECKSUM_EN
   assign bus.cksum          = cksum_q;
`endif

endmodule

// File: tb/tb_mpx_cfg_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mpx_cfg_sequencer
// Directed bench for mpx_cfg_sequencer: one instance with GAP = 2 (FIR loads,
// rejects, abort, async reset) and one with GAP = 0 (DDS load with address
// wrap, optional checksum). Table RAM model: table_m[k] = k + 0x100.
// -----------------------------------------------------------------------------
module tb_mpx_cfg_sequencer;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   mpx_cfg_sequencer_if #(.DATA_WIDTH(25), .ADDR_WIDTH(8)) b2 ();
   mpx_cfg_sequencer_if #(.DATA_WIDTH(25), .ADDR_WIDTH(8)) b0 ();

   mpx_cfg_sequencer #(.DATA_WIDTH(25), .ADDR_WIDTH(8), .GAP(2)) dut2 (
      .clk(clk), .reset_n(reset_n), .bus(b2));
   mpx_cfg_sequencer #(.DATA_WIDTH(25), .ADDR_WIDTH(8), .GAP(0)) dut0 (
      .clk(clk), .reset_n(reset_n), .bus(b0));

   logic [24:0] table_m [0:255];
   always @(posedge clk) if (b2.mem_rd) b2.mem_rdata <= table_m[b2.mem_addr];
   always @(posedge clk) if (b0.mem_rd) b0.mem_rdata <= table_m[b0.mem_addr];

   int n_assert = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Run one FIR load on the GAP=2 instance for a fixed window, checking each
   // strobe's word and cycle. inj_cyc: cycle to pulse a second start (-1 none).
   // abort_str: abort during the strobe with this 1-based number (0 none).
   task automatic run_filter(input logic [7:0] base, input int cnt, input int inj_cyc,
                             input int abort_str, output int nstr, output int done_cyc,
                             output int ndone, output int err_cyc, output int busy_err,
                             output int bad);
      logic [31:0] exp_din;
      nstr = 0; done_cyc = -1; ndone = 0; err_cyc = -1; busy_err = -1; bad = 0;
      b2.target    = 1'b0;
      b2.base_addr = base;
      b2.count     = 9'(cnt);
      b2.start     = 1'b1;
      for (int cyc = 1; cyc <= 130; cyc++) begin
         tick();
         b2.start = (cyc == inj_cyc);
         b2.abort = 1'b0;
         if (cyc == 1) check("busy_rise", b2.busy, 1);
         if (b2.filter_cfg_ce) begin
            exp_din = 32'h100 + 32'(8'(base + 8'(nstr)));
            check("fir_din", b2.filter_cfg_din, exp_din);
            check("fir_strobe_cycle", cyc, 3 + 5 * nstr);
            nstr++;
            if (abort_str != 0 && nstr == abort_str) b2.abort = 1'b1;
         end
         if (b2.dds_cfg_ce) bad++;
         if (b2.mute !== b2.busy) bad++;
         if (b2.done) begin
            ndone++;
            if (done_cyc < 0) done_cyc = cyc;
         end
         if (b2.err && err_cyc < 0) begin
            err_cyc  = cyc;
            busy_err = int'(b2.busy);
         end
      end
   endtask

   int nstr, done_cyc, ndone, err_cyc, busy_err, bad, nrd;
   logic [7:0] exp_a [4];

   initial begin
      for (int k = 0; k < 256; k++) table_m[k] = 25'(k + 'h100);
      b2.start = 0; b2.target = 0; b2.base_addr = 0; b2.count = 0; b2.abort = 0;
      b0.start = 0; b0.target = 0; b0.base_addr = 0; b0.count = 0; b0.abort = 0;
      exp_a[0] = 8'hFE; exp_a[1] = 8'hFF; exp_a[2] = 8'h00; exp_a[3] = 8'h01;

      // reset state
      repeat (3) tick();
      check("rst_busy", b2.busy, 0);
      check("rst_done", b2.done, 0);
      check("rst_err", b2.err, 0);
      check("rst_mute", b2.mute, 0);
      check("rst_mem_rd", b2.mem_rd, 0);
      check("rst_mem_addr", b2.mem_addr, 0);
      check("rst_fir_din", b2.filter_cfg_din, 0);
      check("rst_fir_ce", b2.filter_cfg_ce, 0);
      check("rst_dds_cfg", b2.dds_cfg, 0);
      check("rst_dds_ce", b2.dds_cfg_ce, 0);
`ifdef MPX_CFG_CHECKSUM_EN
      check("rst_cksum", b0.cksum, 0);
`endif
      reset_n = 1'b1;
      tick();

      // 21-word FIR load, base 0x10
      run_filter(8'h10, 21, -1, 0, nstr, done_cyc, ndone, err_cyc, busy_err, bad);
      check("fir_nstrobe", nstr, 21);
      check("fir_done_cycle", done_cyc, 104);
      check("fir_done_pulses", ndone, 1);
      check("fir_no_err", err_cyc, -1);
      check("fir_dds_ce_mute", bad, 0);
      check("fir_din_hold", b2.filter_cfg_din, 25'h124);
      check("fir_busy_after", b2.busy, 0);

      // start with count = 0
      b2.count = 0; b2.start = 1'b1;
      tick();
      b2.start = 1'b0;
      check("zero_err", b2.err, 1);
      check("zero_busy", b2.busy, 0);
      tick();
      check("zero_err_pulse", b2.err, 0);
      check("zero_busy2", b2.busy, 0);
      check("zero_no_ce", b2.filter_cfg_ce, 0);

      // second start during active load
      run_filter(8'h10, 21, 10, 0, nstr, done_cyc, ndone, err_cyc, busy_err, bad);
      check("busy_start_err_cycle", err_cyc, 11);
      check("busy_start_busy", busy_err, 1);
      check("busy_start_nstrobe", nstr, 21);
      check("busy_start_done_cycle", done_cyc, 104);
      check("busy_start_bad", bad, 0);

      // abort during 5th strobe
      run_filter(8'h10, 21, -1, 5, nstr, done_cyc, ndone, err_cyc, busy_err, bad);
      check("abort_nstrobe", nstr, 5);
      check("abort_no_done", ndone, 0);
      check("abort_err_cycle", err_cyc, 24);
      check("abort_busy_low", busy_err, 0);
      check("abort_din_hold", b2.filter_cfg_din, 25'h114);
      check("abort_mute", b2.mute, 0);

      // abort in IDLE is ignored
      b2.abort = 1'b1;
      tick();
      b2.abort = 1'b0;
      check("idle_abort_err", b2.err, 0);
      check("idle_abort_busy", b2.busy, 0);

      // async reset in the middle of PACE, no clock edge
      b2.target = 1'b0; b2.base_addr = 8'h10; b2.count = 9'd21; b2.start = 1'b1;
      tick();
      b2.start = 1'b0;
      repeat (3) tick();
      #2;
      reset_n = 1'b0;
      #1;
      check("arst_busy", b2.busy, 0);
      check("arst_mute", b2.mute, 0);
      check("arst_fir_din", b2.filter_cfg_din, 0);
      check("arst_mem_addr", b2.mem_addr, 0);
      check("arst_fir_ce", b2.filter_cfg_ce, 0);
      reset_n = 1'b1;
      tick();
      run_filter(8'h20, 3, -1, 0, nstr, done_cyc, ndone, err_cyc, busy_err, bad);
      check("arst_reload_nstrobe", nstr, 3);
      check("arst_reload_done_cycle", done_cyc, 14);
      check("arst_reload_din", b2.filter_cfg_din, 25'h122);

      // DDS load, GAP = 0, address wrap
      nrd = 0; nstr = 0; done_cyc = -1; bad = 0;
      b0.target = 1'b1; b0.base_addr = 8'hFE; b0.count = 9'd4; b0.start = 1'b1;
      for (int cyc = 1; cyc <= 30; cyc++) begin
         tick();
         b0.start = 1'b0;
         if (b0.mem_rd) begin
            if (nrd < 4) check("dds_mem_addr", b0.mem_addr, exp_a[nrd]);
            else bad++;
            nrd++;
         end
         if (b0.dds_cfg_ce) begin
            if (nstr < 4) check("dds_cfg", b0.dds_cfg, exp_a[nstr]);
            check("dds_strobe_cycle", cyc, 3 + 3 * nstr);
            nstr++;
         end
         if (b0.filter_cfg_ce || b0.mute) bad++;
         if (b0.done && done_cyc < 0) done_cyc = cyc;
      end
      check("dds_nread", nrd, 4);
      check("dds_nstrobe", nstr, 4);
      check("dds_done_cycle", done_cyc, 13);
      check("dds_fir_ce_mute", bad, 0);
      check("dds_fir_din_untouched", b0.filter_cfg_din, 0);

`ifdef MPX_CFG_CHECKSUM_EN
      table_m[8'h40] = 25'h0FFFF;
      table_m[8'h41] = 25'h00002;
      table_m[8'h42] = 25'h00010;
      done_cyc = -1;
      b0.target = 1'b1; b0.base_addr = 8'h40; b0.count = 9'd3; b0.start = 1'b1;
      for (int cyc = 1; cyc <= 30; cyc++) begin
         tick();
         b0.start = 1'b0;
         if (b0.done && done_cyc < 0) begin
            done_cyc = cyc;
            check("cksum_at_done", b0.cksum, 16'h0011);
         end
      end
      check("cksum_done_cycle", done_cyc, 10);
      check("cksum_hold", b0.cksum, 16'h0011);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/mpx_cfg_sequencer.md
Name: mpx_cfg_sequencer

Overview:
- Bulk-loads configuration into the stereo MPX datapath. Targets are the L/R pre-emphasis FIR coefficient chain (25-bit cfg words, shared by both filters) and the pilot DDS waveform ROM (8-bit words).
- Reads a contiguous word table from a local coefficient RAM and streams it to the selected target, one cfg_ce strobe per word, with programmable pacing.
- Sits beside mpx_regs on the register clock. Firmware issues one start instead of 21+ register writes.
- Drives a mute request so the MPX output can be held while filter taps are inconsistent.

Parameters:
- DATA_WIDTH, 25, width of table words and filter_cfg_din.
- ADDR_WIDTH, 8, table address width.
- GAP, 2, idle cycles between consecutive strobes (0 allowed).

Ports:
- clk  in  1  register/config clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request to begin a load.
- target  in  1  0 = FIR filter chain, 1 = DDS ROM; sampled with start.
- base_addr  in  ADDR_WIDTH  first table address; sampled with start.
- count  in  ADDR_WIDTH+1  number of words; sampled with start.
- abort  in  1  terminate an active load.
- busy  out  1  load in progress.
- done  out  1  one-cycle pulse on normal completion.
- err  out  1  one-cycle pulse on rejected start or abort.
- mute  out  1  high while busy and target = 0.
- mem_addr  out  ADDR_WIDTH  table read address.
- mem_rd  out  1  table read enable; data returns next cycle.
- mem_rdata  in  DATA_WIDTH  table read data.
- filter_cfg_din  out  DATA_WIDTH  filter config word.
- filter_cfg_ce  out  1  filter config strobe.
- dds_cfg  out  8  DDS ROM word (mem_rdata[7:0]).
- dds_cfg_ce  out  1  DDS ROM write strobe.

Behaviour:
- Clocking and reset: single clock clk; reset_n is asynchronous, active-low. While reset_n is low:
  - state = IDLE;
  - all outputs 0, including filter_cfg_din, dds_cfg and mem_addr;
  - word index i = 0.
- State machine: IDLE, READ, LATCH, STROBE, PACE, DONE.
  - IDLE: on start with count != 0, latch target/base_addr/count, set i = 0, go to READ. busy is registered and rises the cycle after start.
  - READ: mem_rd = 1, mem_addr = base_addr + i (mod 2^ADDR_WIDTH). Go to LATCH.
  - LATCH: capture mem_rdata into filter_cfg_din (target 0) or dds_cfg (target 1). The non-selected output is unchanged. Go to STROBE.
  - STROBE: exactly one of filter_cfg_ce / dds_cfg_ce = 1 for one cycle; data is stable this cycle. Then i++:
    - if i == count, go to DONE;
    - else if GAP > 0, go to PACE;
    - else go to READ.
  - PACE: hold for GAP cycles, then go to READ.
  - DONE: done = 1, busy = 0, return to IDLE.
- Timing: per word 3 cycles, plus GAP between words. N words take 3N + GAP(N-1) cycles from entering READ. done is high the cycle after the last STROBE.
- Config outputs hold their last value after completion or abort.
- Rejected start:
  - start with count = 0 gives err pulse next cycle; no busy, no strobe.
  - start while busy is ignored and gives an err pulse; the active load continues unaffected.
- Abort:
  - abort while busy: next state IDLE, busy drops next cycle, err pulses, no done, no further mem_rd or strobes.
  - A strobe already present in the abort cycle completes.
  - abort coincident with the final STROBE: abort wins, so no done and err = 1.
  - abort in IDLE is ignored.
- Address wrap: mem_addr wraps modulo 2^ADDR_WIDTH. count > 2^ADDR_WIDTH re-reads wrapped addresses.
- start and abort in the same IDLE cycle: abort ignored, start accepted.
- mute = busy & ~target_latched, registered alongside busy.

Optional Feature:
- Macro MPX_CFG_CHECKSUM_EN.
- Defined:
  - adds output cksum [15:0], the wrapping 16-bit sum of mem_rdata[15:0] over all strobed words of the last load;
  - cleared to 0 on accepted start, valid when done pulses, held thereafter, 0 on reset.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Filter load: target=0, base=0x10, count=21, GAP=2, table[k] = k+0x100 → 21 filter_cfg_ce pulses with din 0x110..0x124, 5-cycle spacing; done 104 cycles after the start edge; dds_cce never high; mute high throughout busy.
- DDS load: target=1, base=0xFE, count=4, GAP=0 → dds_cfg_ce pulses back-to-back every 3 cycles; mem_addr sequence FE, FF, 00, 01 (wrap); dds_cfg = low bytes; mute stays 0.
- Reject: start with count=0 → err pulse, busy stays 0; start during an active load → err pulse, strobe count and done timing unchanged.
- Abort after 5th strobe of a 21-word load → exactly 5 strobes, err pulse, no done, filter_cfg_din holds word 4, busy low next cycle.
- Async reset: drop reset_n mid-PACE with no clock edge → all outputs 0 immediately; a subsequent start loads correctly from i=0.
- With MPX_CFG_CHECKSUM_EN defined: 3 words 0xFFFF, 0x0002, 0x0010 → cksum = 0x0011 at done.
